pipe_divider: RTL and testbench



---
 rtl/pipe_divider_pkg.sv | 25 ++
 rtl/pipe_divider_div_step.sv | 28 ++
 rtl/pipe_divider.sv | 94 +++++++++
 tb/tb_pipe_divider.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_divider_pkg.sv
// Shared definitions for the pipelined restoring divider.
// Holds the width constants, the divide-by-zero quotient value and the
// per-stage register struct carried down the pipeline.
package pipe_divider_pkg;

   localparam int DW             = 8;   // dividend / quotient width
   localparam int VW             = 4;   // divisor / remainder width
   localparam int STAGES         = 4;   // pipeline depth
   localparam int BITS_PER_STAGE = 2;   // quotient bits resolved per stage

   localparam logic [DW-1:0] DBZ_QUOTIENT = 8'hFF;

   // One pipeline stage register. dividend_rem is kept left-aligned: its two
   // MSBs are the next dividend bits to consume. q fills from the LSB end, so
   // after the last stage it holds the full quotient MSB-first.
   typedef struct packed {
      logic          valid;
      logic          dbz;
      logic [DW-1:0] dividend_rem;
      logic [VW-1:0] divisor;
      logic [VW:0]   prem;
      logic [DW-1:0] q;
   } stage_t;

endpackage

// File: rtl/pipe_divider_div_step.sv
// div_step: one combinational restoring-division step.
//   prem_in  [VW:0]  partial remainder in (always < divisor, so bit VW is 0)
//   din              next dividend bit, MSB first
//   divisor  [VW-1:0]
//   prem_out [VW:0]  partial remainder after the step
//   qbit             resolved quotient bit
module div_step
   import pipe_divider_pkg::*;
(
   input  logic [VW:0]   prem_in,
   input  logic          din,
   input  logic [VW-1:0] divisor,
   output logic [VW:0]   prem_out,
   output logic          qbit
);

   logic [VW:0] r5;
   logic        unused_prem_msb;

   // Partial remainder is < divisor, so its top bit is always 0 and the
   // shifted value still fits in VW+1 bits.
   assign r5              = {prem_in[VW-1:0], din};
   assign unused_prem_msb = prem_in[VW];

   assign qbit     = (r5 >= {1'b0, divisor});
   assign prem_out = qbit ? (r5 - {1'b0, divisor}) : r5;

endmodule

// File: rtl/pipe_divider.sv
// pipe_divider: 4-stage pipelined unsigned restoring divider.
// 8-bit dividend / 4-bit divisor -> 8-bit quotient + 4-bit remainder, two
// quotient bits per stage, latency 4 enabled edges, one result per enabled
// cycle. Divisor 0 yields dbz=1, quotient=8'hFF, remainder=0.
//   clk        rising-edge clock
//   rst        synchronous reset, active-high, wins over en
//   en         pipeline advance; 0 holds every register including valids
//   in_valid   dividend/divisor qualify this cycle
//   dividend   [7:0] unsigned dividend
//   divisor    [3:0] unsigned divisor
//   out_valid  result valid (held while en=0)
//   quotient   [7:0], remainder [3:0], dbz  result of the op
module pipe_divider
   import pipe_divider_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          in_valid,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic          out_valid,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          dbz
);

   stage_t stg [STAGES];   // stage registers; the last one is the output
   stage_t nxt [STAGES];   // next-state value for each stage register

   for (genvar s = 0; s < STAGES; s++) begin : g_stage
      stage_t      src;
      logic [VW:0] prem_a, prem_b;
      logic        q_a, q_b;

      // Stage 1 starts from the raw inputs with a zero partial remainder.
      if (s == 0) begin : g_first
         assign src = '{valid:        in_valid,
                        dbz:          (divisor == '0),
                        dividend_rem: dividend,
                        divisor:      divisor,
                        prem:         {(VW+1){1'b0}},
                        q:            {DW{1'b0}}};
      end else begin : g_rest
         assign src = stg[s-1];
      end

      div_step u_step_a (
         .prem_in  (src.prem),
         .din      (src.dividend_rem[DW-1]),
         .divisor  (src.divisor),
         .prem_out (prem_a),
         .qbit     (q_a)
      );

      div_step u_step_b (
         .prem_in  (prem_a),
         .din      (src.dividend_rem[DW-2]),
         .divisor  (src.divisor),
         .prem_out (prem_b),
         .qbit     (q_b)
      );

      // A dbz op pins its quotient/remainder so the meaningless steps on a
      // zero divisor never leak into the result.
      assign nxt[s] = '{valid:        src.valid,
                        dbz:          src.dbz,
                        dividend_rem: {src.dividend_rem[DW-BITS_PER_STAGE-1:0],
                                       {BITS_PER_STAGE{1'b0}}},
                        divisor:      src.divisor,
                        prem:         src.dbz ? {(VW+1){1'b0}} : prem_b,
                        q:            src.dbz ? DBZ_QUOTIENT
                                              : {src.q[DW-BITS_PER_STAGE-1:0], q_a, q_b}};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) stg[i] <= '0;
      end else if (en) begin
         for (int i = 0; i < STAGES; i++) stg[i] <= nxt[i];
      end
   end

   assign out_valid = stg[STAGES-1].valid;
   assign quotient  = stg[STAGES-1].q;
   assign remainder = stg[STAGES-1].prem[VW-1:0];
   assign dbz       = stg[STAGES-1].dbz;

   // Fields that only matter inside the pipeline.
   logic unused_tail;
   assign unused_tail = ^{stg[STAGES-1].dividend_rem, stg[STAGES-1].divisor,
                          stg[STAGES-1].prem[VW]};

endmodule

// File: tb/tb_pipe_divider.sv
// Scoreboard bench for pipe_divider: stimulus pushes expected results into a
// queue, an independent monitor pops and compares on every fresh out_valid.
module tb_pipe_divider;

   logic       clk = 1'b0;
   logic       rst, en, in_valid;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       out_valid, dbz;
   logic [7:0] quotient;
   logic [3:0] remainder;

   int errors = 0;
   int checks = 0;

   logic [12:0] exp_q [$];    // {quotient, remainder, dbz}
   logic [12:0] exp_e;
   logic        fresh = 1'b0; // output register was loaded at the last edge

   pipe_divider dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .in_valid  (in_valid),
      .dividend  (dividend),
      .divisor   (divisor),
      .out_valid (out_valid),
      .quotient  (quotient),
      .remainder (remainder),
      .dbz       (dbz)
   );

   always #5 clk = ~clk;

   always @(posedge clk) fresh <= en & ~rst;

   // Monitor
   always @(negedge clk) begin
      if (fresh && out_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out: got q=%0d r=%0d dbz=%0d, required no output",
                     quotient, remainder, dbz);
         end else begin
            exp_e = exp_q.pop_front();
            if ({quotient, remainder, dbz} !== exp_e) begin
               errors++;
               $display("FAIL result: got q=%0d r=%0d dbz=%0d, required q=%0d r=%0d dbz=%0d",
                        quotient, remainder, dbz, exp_e[12:5], exp_e[4:1], exp_e[0]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
      checks++;
      if (got !== req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, got, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one op for one edge and record its hand-computed result.
   task automatic send(input logic [7:0] a, input logic [3:0] b,
                       input logic [7:0] eq, input logic [3:0] er, input logic ed);
      in_valid = 1'b1;
      dividend = a;
      divisor  = b;
      exp_q.push_back({eq, er, ed});
      step();
      in_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   function automatic logic [12:0] ref_div(input logic [7:0] a, input logic [3:0] b);
      logic [7:0] q;
      logic [7:0] r;
      if (b == 4'd0) return {8'hFF, 4'h0, 1'b1};
      q = a / {4'd0, b};
      r = a % {4'd0, b};
      return {q, r[3:0], 1'b0};
   endfunction

   logic [13:0] snap;
   logic [12:0] m;

   initial begin
      rst = 1'b1; en = 1'b0; in_valid = 1'b0; dividend = '0; divisor = '0;
      step(); step();
      chk("reset_out_valid", {31'd0, out_valid}, 0);
      chk("reset_quotient",  {24'd0, quotient},  0);
      chk("reset_remainder", {28'd0, remainder}, 0);
      chk("reset_dbz",       {31'd0, dbz},       0);

      // Latency: result only after the 4th enabled edge
      rst = 1'b0; en = 1'b1;
      send(8'd200, 4'd13, 8'd15, 4'd5, 1'b0);
      chk("lat_edge_k",   {31'd0, out_valid}, 0);
      step(); chk("lat_edge_k1", {31'd0, out_valid}, 0);
      step(); chk("lat_edge_k2", {31'd0, out_valid}, 0);
      step(); chk("lat_edge_k3", {31'd0, out_valid}, 1);
      idle(3);

      // Streaming, back-to-back results
      send(8'd255, 4'd1,  8'd255, 4'd0, 1'b0);
      send(8'd7,   4'd9,  8'd0,   4'd7, 1'b0);
      send(8'd195, 4'd13, 8'd15,  4'd0, 1'b0);
      send(8'd0,   4'd5,  8'd0,   4'd0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         chk("stream_b2b_valid", {31'd0, out_valid}, 1);
         step();
      end
      chk("stream_bubble", {31'd0, out_valid}, 0);

      // Divide-by-zero inside a stream
      send(8'd100, 4'd3, 8'd33,  4'd1, 1'b0);
      send(8'd50,  4'd0, 8'd255, 4'd0, 1'b1);
      send(8'd100, 4'd7, 8'd14,  4'd2, 1'b0);
      idle(4);

      // Stall mid-flight
      send(8'd225, 4'd15, 8'd15, 4'd0, 1'b0);
      step();
      en = 1'b0;
      snap = {out_valid, quotient, remainder, dbz};
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_frozen", {18'd0, out_valid, quotient, remainder, dbz}, {18'd0, snap});
      end
      en = 1'b1;
      step(); chk("stall_edge3_valid", {31'd0, out_valid}, 0);
      step(); chk("stall_edge4_valid", {31'd0, out_valid}, 1);
      // Held valid while stalled with a result at the output
      en = 1'b0;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("stall_hold_result", {18'd0, out_valid, quotient, remainder, dbz},
             {18'd0, 1'b1, 8'd15, 4'd0, 1'b0});
      end
      en = 1'b1;
      idle(4);

      // Reset mid-flight: none of these three may ever emerge
      send(8'd9, 4'd2, 8'd4, 4'd1, 1'b0);
      send(8'd8, 4'd4, 8'd2, 4'd0, 1'b0);
      send(8'd7, 4'd7, 8'd1, 4'd0, 1'b0);
      exp_q.delete();
      rst = 1'b1;
      step();
      chk("rst_mid_valid",     {31'd0, out_valid}, 0);
      chk("rst_mid_quotient",  {24'd0, quotient},  0);
      chk("rst_mid_remainder", {28'd0, remainder}, 0);
      chk("rst_mid_dbz",       {31'd0, dbz},       0);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("rst_mid_no_emerge", {31'd0, out_valid}, 0);
      end

      // Exhaustive stream against the reference model
      for (int a = 0; a < 256; a++) begin
         for (int b = 0; b < 16; b++) begin
            m = ref_div(a[7:0], b[3:0]);
            send(a[7:0], b[3:0], m[12:5], m[4:1], m[0]);
         end
      end
      idle(6);

      chk("drain_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
